branch_control_unit: RTL



---
 rtl/branch_control_unit.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/branch_control_unit.sv
// rtl/branch_control_unit.sv - hardwired fetch/decode/execute sequencer for the CPU datapath
// Optional: CTRL_STRICT_DECODE_EN traps undefined opcodes in an ILLEGAL state.
module branch_control_unit #(
  parameter logic [4:0] ALU_ADD = 5'b00001,
  parameter logic [4:0] OP_ADDI = 5'b01100,
  parameter logic [4:0] OP_BR   = 5'b10011,
  parameter logic [4:0] OP_JR   = 5'b10100,
  parameter logic [4:0] OP_JAL  = 5'b10101,
  parameter logic [4:0] OP_NOP  = 5'b11010,
  parameter logic [4:0] OP_HALT = 5'b11011
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON_FF_Out,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MDRread,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLowout,
  output logic        Gra,
  output logic        Grb,
  output logic        Rin,
  output logic        Rout,
  output logic        Cout,
  output logic        CON_FF_In,
  output logic        R15in,
  output logic [4:0]  ALUSelection,
  output logic        run,
  output logic        illegal
);

  typedef enum logic [4:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_DEC,
    S_BR3,
    S_BR4,
    S_BR5,
    S_BR6,
    S_JR3,
    S_JAL3,
    S_JAL4,
    S_AD3,
    S_AD4,
    S_AD5,
`ifdef CTRL_STRICT_DECODE_EN
    S_ILLEGAL,
`endif
    S_HALT
  } state_t;

  state_t state, state_next;

  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  always_ff @(posedge clk) begin
    if (clr) state <= S_IDLE;
    else     state <= state_next;
  end

  // Opcode is only looked at in DEC; IR is free to change elsewhere.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: state_next = S_T0;
      S_T0:   state_next = S_T1;
      S_T1:   state_next = S_T2;
      S_T2:   state_next = S_DEC;
      S_DEC: begin
        if      (opcode == OP_BR)   state_next = S_BR3;
        else if (opcode == OP_JR)   state_next = S_JR3;
        else if (opcode == OP_JAL)  state_next = S_JAL3;
        else if (opcode == OP_ADDI) state_next = S_AD3;
        else if (opcode == OP_HALT) state_next = S_HALT;
        else if (opcode == OP_NOP)  state_next = S_T0;
        else begin
`ifdef CTRL_STRICT_DECODE_EN
          state_next = S_ILLEGAL;
`else
          state_next = S_T0;
`endif
        end
      end
      S_BR3:  state_next = S_BR4;
      S_BR4:  state_next = S_BR5;
      S_BR5:  state_next = S_BR6;
      S_BR6:  state_next = S_T0;
      S_JR3:  state_next = S_T0;
      S_JAL3: state_next = S_JAL4;
      S_JAL4: state_next = S_T0;
      S_AD3:  state_next = S_AD4;
      S_AD4:  state_next = S_AD5;
      S_AD5:  state_next = S_T0;
`ifdef CTRL_STRICT_DECODE_EN
      S_ILLEGAL: state_next = S_ILLEGAL;
`endif
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    PCout        = 1'b0;
    PCin         = 1'b0;
    IncPC        = 1'b0;
    MARin        = 1'b0;
    MDRin        = 1'b0;
    MDRout       = 1'b0;
    MDRread      = 1'b0;
    IRin         = 1'b0;
    Yin          = 1'b0;
    Zin          = 1'b0;
    ZLowout      = 1'b0;
    Gra          = 1'b0;
    Grb          = 1'b0;
    Rin          = 1'b0;
    Rout         = 1'b0;
    Cout         = 1'b0;
    CON_FF_In    = 1'b0;
    R15in        = 1'b0;
    ALUSelection = 5'b00000;
    run          = 1'b1;
    illegal      = 1'b0;
    unique case (state)
      S_IDLE: run = 1'b0;
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        ZLowout = 1'b1;
        PCin    = 1'b1;
        MDRread = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_DEC: ;
      S_BR3: begin
        Gra       = 1'b1;
        Rout      = 1'b1;
        CON_FF_In = 1'b1;
      end
      S_BR4: begin
        PCout = 1'b1;
        Yin   = 1'b1;
      end
      S_BR5: begin
        Cout         = 1'b1;
        ALUSelection = ALU_ADD;
        Zin          = 1'b1;
      end
      // Branch target is committed only if the condition flop was set in BR3.
      S_BR6: begin
        ZLowout = 1'b1;
        PCin    = CON_FF_Out;
      end
      S_JR3: begin
        Gra  = 1'b1;
        Rout = 1'b1;
        PCin = 1'b1;
      end
      S_JAL3: begin
        PCout = 1'b1;
        R15in = 1'b1;
      end
      S_JAL4: begin
        Gra  = 1'b1;
        Rout = 1'b1;
        PCin = 1'b1;
      end
      S_AD3: begin
        Grb  = 1'b1;
        Rout = 1'b1;
        Yin  = 1'b1;
      end
      S_AD4: begin
        Cout         = 1'b1;
        ALUSelection = ALU_ADD;
        Zin          = 1'b1;
      end
      S_AD5: begin
        ZLowout = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
      end
`ifdef CTRL_STRICT_DECODE_EN
      S_ILLEGAL: begin
        run     = 1'b0;
        illegal = 1'b1;
      end
`endif
      S_HALT: run = 1'b0;
      default: run = 1'b0;
    endcase
  end

endmodule
